// File: rtl/axi_ddr_slave_model.sv
// AXI slave backed by a MEM_DEPTH-beat synchronous RAM, standing in for the DDR controller.
// Optional macro AXI_SLV_BP_EN adds LFSR-driven wready/rvalid backpressure.
module axi_ddr_slave_model #(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int MEM_DQ_WIDTH    = 32,
    parameter int MEM_DEPTH       = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CTRL_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [3:0]                   axi_awid,
    input  logic [3:0]                   axi_awlen,
    input  logic [2:0]                   axi_awsize,
    input  logic [1:0]                   axi_awburst,
    input  logic                         axi_awvalid,
    output logic                         axi_awready,
    input  logic [MEM_DQ_WIDTH*8-1:0]    axi_wdata,
    input  logic [MEM_DQ_WIDTH-1:0]      axi_wstrb,
    input  logic                         axi_wvalid,
    output logic                         axi_wready,
    output logic                         axi_wlast,
    output logic [3:0]                   axi_bid,
    output logic [1:0]                   axi_bresp,
    output logic                         axi_bvalid,
    input  logic                         axi_bready,
    input  logic [CTRL_ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [3:0]                   axi_arid,
    input  logic [3:0]                   axi_arlen,
    input  logic [2:0]                   axi_arsize,
    input  logic [1:0]                   axi_arburst,
    input  logic                         axi_arvalid,
    output logic                         axi_arready,
    output logic [MEM_DQ_WIDTH*8-1:0]    axi_rdata,
    output logic [3:0]                   axi_rid,
    output logic [1:0]                   axi_rresp,
    output logic                         axi_rvalid,
    output logic                         axi_rlast,
    input  logic                         axi_rready
);
    localparam int BW = MEM_DQ_WIDTH * 8;
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    logic [BW-1:0] mem [MEM_DEPTH];

    wstate_t       w_state_q;
    logic          awready_q, wready_q, bvalid_q, werr_q;
    logic [3:0]    bid_q, wlen_q, wcnt_q;
    logic [1:0]    bresp_q;
    logic [AW-1:0] widx_q;

    rstate_t       r_state_q;
    logic          arready_q, rvalid_q;
    logic [3:0]    rid_q, rlen_q, rcnt_q;
    logic [1:0]    rresp_q;
    logic [AW-1:0] ridx_q, raddr;
    logic [BW-1:0] rdata_q;

    logic w_stall, r_hold, w_fire, r_fire, ren;

`ifdef AXI_SLV_BP_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
    assign w_stall = lfsr_q[0];
    assign r_hold  = lfsr_q[1];
`else
    assign w_stall = 1'b0;
    assign r_hold  = 1'b0;
`endif

    assign axi_awready = awready_q;
    assign axi_wready  = wready_q & ~w_stall;
    assign axi_wlast   = axi_wready & (wcnt_q == wlen_q);
    assign axi_bvalid  = bvalid_q;
    assign axi_bid     = bid_q;
    assign axi_bresp   = bresp_q;
    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rlast   = rvalid_q & (rcnt_q == rlen_q);
    assign axi_rid     = rid_q;
    assign axi_rresp   = rresp_q;
    assign axi_rdata   = rdata_q;

    assign w_fire = axi_wvalid & axi_wready;
    assign r_fire = rvalid_q & axi_rready;
    // rdata_q only reloads on fetch or an accepted non-last beat, so it holds during a stall
    assign ren    = (r_state_q == R_FETCH) | (r_fire & ~axi_rlast);
    assign raddr  = r_fire ? ridx_q + 1'b1 : ridx_q;

    logic unused_addr;
    assign unused_addr = ^{axi_awaddr[CTRL_ADDR_WIDTH-1:AW+3], axi_awaddr[2:0],
                           axi_araddr[CTRL_ADDR_WIDTH-1:AW+3], axi_araddr[2:0]};

    always_ff @(posedge clk) begin
        if (w_fire && !rst) begin
            for (int b = 0; b < MEM_DQ_WIDTH; b++) begin
                if (axi_wstrb[b]) mem[widx_q][8*b +: 8] <= axi_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)      rdata_q <= '0;
        else if (ren) rdata_q <= mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            werr_q    <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            widx_q    <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (awready_q && axi_awvalid) begin
                        widx_q    <= axi_awaddr[AW+2:3];
                        wlen_q    <= axi_awlen;
                        bid_q     <= axi_awid;
                        werr_q    <= (axi_awburst != 2'b01) || (axi_awsize != 3'b101);
                        wcnt_q    <= '0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        widx_q <= widx_q + 1'b1;
                        wcnt_q <= wcnt_q + 4'd1;
                        if (axi_wlast) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= werr_q ? 2'b10 : 2'b00;
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            ridx_q    <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (arready_q && axi_arvalid) begin
                        ridx_q    <= axi_araddr[AW+2:3];
                        rlen_q    <= axi_arlen;
                        rid_q     <= axi_arid;
                        rresp_q   <= ((axi_arburst != 2'b01) || (axi_arsize != 3'b101)) ? 2'b10 : 2'b00;
                        rcnt_q    <= '0;
                        arready_q <= 1'b0;
                        r_state_q <= R_FETCH;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_FETCH: begin
                    rvalid_q  <= ~r_hold;
                    r_state_q <= R_DATA;
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (axi_rlast) begin
                            rvalid_q  <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            ridx_q   <= ridx_q + 1'b1;
                            rcnt_q   <= rcnt_q + 4'd1;
                            rvalid_q <= ~r_hold;
                        end
                    end else if (!rvalid_q) begin
                        rvalid_q <= ~r_hold;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_ddr_slave_model.sv
// Directed bench for axi_ddr_slave_model with a shadow-memory scoreboard on the read channel.
module tb_axi_ddr_slave_model;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [27:0]  axi_awaddr = '0, axi_araddr = '0;
    logic [3:0]   axi_awid = '0, axi_awlen = '0, axi_arid = '0, axi_arlen = '0;
    logic [2:0]   axi_awsize = 3'b101, axi_arsize = 3'b101;
    logic [1:0]   axi_awburst = 2'b01, axi_arburst = 2'b01;
    logic         axi_awvalid = 1'b0, axi_wvalid = 1'b0, axi_bready = 1'b0;
    logic         axi_arvalid = 1'b0, axi_rready = 1'b0;
    logic [255:0] axi_wdata = '0;
    logic [31:0]  axi_wstrb = '0;
    logic         axi_awready, axi_wready, axi_wlast, axi_bvalid;
    logic [3:0]   axi_bid, axi_rid;
    logic [1:0]   axi_bresp, axi_rresp;
    logic         axi_arready, axi_rvalid, axi_rlast;
    logic [255:0] axi_rdata;

    axi_ddr_slave_model dut (
        .clk(clk), .rst(rst),
        .axi_awaddr(axi_awaddr), .axi_awid(axi_awid), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_wlast(axi_wlast),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arid(axi_arid), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rresp(axi_rresp),
        .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast), .axi_rready(axi_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [255:0] d;
        logic         l;
        logic [3:0]   id;
        logic [1:0]   resp;
    } exp_t;

    exp_t         sb[$];
    logic [255:0] wdat_q[$];
    logic [255:0] shadow [1024];
    int           n_checks = 0;
    int           n_err = 0;
    int           cyc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_err++;
        $error("FAIL %s: timeout waiting for DUT", tag);
    endtask

    task automatic wr(input logic [27:0] addr, input logic [3:0] len, input logic [3:0] id,
                      input logic [1:0] burst, input logic [31:0] strb);
        int t;
        int idx;
        axi_awaddr = addr; axi_awlen = len; axi_awid = id; axi_awburst = burst;
        axi_awvalid = 1'b1;
        t = 0;
        while (!axi_awready && t < 100) begin tick(); t++; end
        if (t >= 100) begin timeout("aw"); axi_awvalid = 1'b0; return; end
        tick();
        axi_awvalid = 1'b0;
        idx = int'(addr[12:3]);
        for (int i = 0; i <= int'(len); i++) begin
            axi_wdata = wdat_q[i]; axi_wstrb = strb; axi_wvalid = 1'b1;
            t = 0;
            while (!axi_wready && t < 100) begin tick(); t++; end
            if (t >= 100) begin timeout("w"); axi_wvalid = 1'b0; return; end
            chk("wlast", 256'(axi_wlast), 256'(i == int'(len)));
            for (int b = 0; b < 32; b++)
                if (strb[b]) shadow[(idx + i) % 1024][8*b +: 8] = wdat_q[i][8*b +: 8];
            tick();
        end
        axi_wvalid = 1'b0;
        axi_bready = 1'b1;
        t = 0;
        while (!axi_bvalid && t < 100) begin tick(); t++; end
        if (t >= 100) begin timeout("b"); axi_bready = 1'b0; return; end
        chk("bid", 256'(axi_bid), 256'(id));
        chk("bresp", 256'(axi_bresp), (burst != 2'b01) ? 256'd2 : 256'd0);
        tick();
        axi_bready = 1'b0;
        chk("bvalid_drop", 256'(axi_bvalid), 256'd0);
    endtask

    task automatic rd(input logic [27:0] addr, input logic [3:0] len, input logic [3:0] id,
                      input logic [1:0] burst, input bit toggle, output int cycles);
        int t;
        int idx;
        bit held;
        logic [255:0] hold_d;
        exp_t e;
        cycles = 0;
        idx = int'(addr[12:3]);
        for (int i = 0; i <= int'(len); i++)
            sb.push_back('{shadow[(idx + i) % 1024], i == int'(len), id,
                           (burst != 2'b01) ? 2'b10 : 2'b00});
        axi_araddr = addr; axi_arlen = len; axi_arid = id; axi_arburst = burst;
        axi_arvalid = 1'b1;
        t = 0;
        while (!axi_arready && t < 100) begin tick(); t++; end
        if (t >= 100) begin timeout("ar"); axi_arvalid = 1'b0; sb.delete(); return; end
        tick();
        axi_arvalid = 1'b0;
        chk("rvalid_hs+1", 256'(axi_rvalid), 256'd0);
        tick();
        chk("rvalid_hs+2", 256'(axi_rvalid), 256'd1);
        held = 1'b0;
        t = 0;
        while (sb.size() > 0 && t < 200) begin
            axi_rready = toggle ? (cycles % 2 == 0) : 1'b1;
            if (held) chk("rdata_stable", axi_rdata, hold_d);
            held = 1'b0;
            if (axi_rvalid) begin
                cycles++;
                if (axi_rready) begin
                    e = sb.pop_front();
                    chk("rdata", axi_rdata, e.d);
                    chk("rlast", 256'(axi_rlast), 256'(e.l));
                    chk("rid", 256'(axi_rid), 256'(e.id));
                    chk("rresp", 256'(axi_rresp), 256'(e.resp));
                end else begin
                    held = 1'b1;
                    hold_d = axi_rdata;
                end
            end
            tick();
            t++;
        end
        axi_rready = 1'b0;
        if (sb.size() > 0) begin timeout("r"); sb.delete(); end
        chk("rvalid_end", 256'(axi_rvalid), 256'd0);
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_awready", 256'(axi_awready), 256'd0);
        chk("rst_arready", 256'(axi_arready), 256'd0);
        chk("rst_wready", 256'(axi_wready), 256'd0);
        chk("rst_bvalid", 256'(axi_bvalid), 256'd0);
        chk("rst_rvalid", 256'(axi_rvalid), 256'd0);
        chk("rst_rdata", axi_rdata, 256'd0);
        rst = 1'b0;
        tick();
        chk("awready_rise", 256'(axi_awready), 256'd1);
        chk("arready_rise", 256'(axi_arready), 256'd1);

        // single beat
        wdat_q.delete(); wdat_q.push_back({32{8'hA5}});
        wr(28'h000, 4'd0, 4'd3, 2'b01, 32'hFFFF_FFFF);
        rd(28'h000, 4'd0, 4'd3, 2'b01, 1'b0, cyc);

        // 16-beat burst, full throughput
        wdat_q.delete();
        for (int i = 0; i < 16; i++) wdat_q.push_back(256'(i));
        wr(28'h040, 4'd15, 4'd5, 2'b01, 32'hFFFF_FFFF);
        rd(28'h040, 4'd15, 4'd5, 2'b01, 1'b0, cyc);
        chk("burst16_cycles", 256'(cyc), 256'd16);

        // byte strobes
        wdat_q.delete(); wdat_q.push_back({32{8'hFF}});
        wr(28'h200, 4'd0, 4'd1, 2'b01, 32'hFFFF_FFFF);
        wdat_q.delete(); wdat_q.push_back({32{8'h11}});
        wr(28'h200, 4'd0, 4'd1, 2'b01, 32'h0000_000F);
        rd(28'h200, 4'd0, 4'd1, 2'b01, 1'b0, cyc);

        // wrap at top of memory, read with rready toggling
        wdat_q.delete();
        for (int i = 0; i < 4; i++) wdat_q.push_back({8{32'hC0DE_0000 + 32'(i)}});
        wr(28'h1FF0, 4'd3, 4'd7, 2'b01, 32'hFFFF_FFFF);
        rd(28'h1FF0, 4'd3, 4'd7, 2'b01, 1'b1, cyc);
        chk("wrap_cycles", 256'(cyc), 256'd7);
        rd(28'h000, 4'd1, 4'd7, 2'b01, 1'b0, cyc);

        // error response on non-INCR burst
        wdat_q.delete(); wdat_q.push_back({16{16'hBEEF}}); wdat_q.push_back({16{16'hCAFE}});
        wr(28'h300, 4'd1, 4'd9, 2'b10, 32'hFFFF_FFFF);
        rd(28'h300, 4'd1, 4'd9, 2'b10, 1'b0, cyc);

        // reset in the middle of a read burst
        axi_araddr = 28'h040; axi_arlen = 4'd15; axi_arid = 4'd2; axi_arburst = 2'b01;
        axi_arvalid = 1'b1;
        tick();
        axi_arvalid = 1'b0;
        axi_rready = 1'b1;
        tick(); tick(); tick();
        chk("mid_rvalid", 256'(axi_rvalid), 256'd1);
        rst = 1'b1;
        axi_rready = 1'b0;
        tick();
        chk("midrst_rvalid", 256'(axi_rvalid), 256'd0);
        chk("midrst_arready", 256'(axi_arready), 256'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_arready", 256'(axi_arready), 256'd1);
        chk("post_rst_rvalid", 256'(axi_rvalid), 256'd0);
        rd(28'h040, 4'd1, 4'd4, 2'b01, 1'b0, cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/axi_ddr_slave_model.md
Name: axi_ddr_slave_model

Overview:
- On-chip AXI responder that plays the DDR-controller end of the AXI channel set driven by the DDR write/read command path.
- Same port dialect as that master: 4-bit len/id, INCR only, and slave-driven axi_wlast.
- Backed by a synchronous RAM of MEM_DEPTH beats. Used as a DDR stand-in for simulation and DDR-less FPGA bring-up of the CNN data path.
- Independent write and read state machines.

Parameters:
- CTRL_ADDR_WIDTH, 28, AXI address width (address unit = one MEM_DQ_WIDTH-bit word)
- MEM_DQ_WIDTH, 32, DDR DQ width; beat = MEM_DQ_WIDTH*8 bits
- MEM_DEPTH, 1024, RAM depth in beats, power of two; AW = log2(MEM_DEPTH)

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous active-high reset
- axi_awaddr  in  CTRL_ADDR_WIDTH  write burst start address
- axi_awid  in  4  write id
- axi_awlen  in  4  beats-1
- axi_awsize  in  3  expected 3'b101
- axi_awburst  in  2  expected 2'b01
- axi_awvalid  in  1  AW valid
- axi_awready  out  1  AW ready
- axi_wdata  in  MEM_DQ_WIDTH*8  write beat
- axi_wstrb  in  MEM_DQ_WIDTH  byte enables
- axi_wvalid  in  1  W valid
- axi_wready  out  1  W ready
- axi_wlast  out  1  slave-driven last-beat flag
- axi_bid  out  4  response id
- axi_bresp  out  2  write response
- axi_bvalid  out  1  B valid
- axi_bready  in  1  B ready
- axi_araddr / axi_arid / axi_arlen / axi_arsize / axi_arburst  in  CTRL_ADDR_WIDTH/4/4/3/2  read request fields
- axi_arvalid  in  1  AR valid
- axi_arready  out  1  AR ready
- axi_rdata  out  MEM_DQ_WIDTH*8  read beat
- axi_rid  out  4  read id
- axi_rresp  out  2  read response
- axi_rvalid  out  1  R valid
- axi_rlast  out  1  last read beat
- axi_rready  in  1  R ready

Behaviour:
- Clock/reset: one clock clk; reset rst is synchronous, active-high.
- Reset values: all outputs 0. RAM contents are not reset.
- After rst deasserts, axi_awready and axi_arready rise on the next clk.
- Beat index: addr[AW+2:3], i.e. addr/8, taken modulo MEM_DEPTH. Increments by 1 per beat and wraps from MEM_DEPTH-1 to 0.
- Error flag: err = (burst != 2'b01) or (size != 3'b101), latched at address accept. Data is still moved as INCR; resp = err ? 2'b10 : 2'b00.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On awvalid, latch idx, len, id, err; awready=0 next cycle; go W_DATA.
  - W_DATA: wready=1. wlast=1 combinationally with wready when beat count == len.
  - Each wvalid&wready: write RAM[idx] byte-wise per wstrb, idx++, count++.
  - Beat with wlast: go W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp per err, held until bready; then W_IDLE.
- Read FSM R_IDLE -> R_FETCH -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On arvalid, latch idx, len, id, err; go R_FETCH.
  - R_FETCH: issue RAM read of idx. First rvalid is 2 cycles after the AR handshake.
  - R_DATA: rvalid=1, rid, rresp. rlast=1 when count == len.
  - RAM read address = (rvalid&rready) ? idx+1 : idx, so bursts run at full throughput (one beat per clk).
  - rdata stays stable while rready=0.
  - Handshake with rlast: rvalid=0 next cycle; go R_IDLE.
- Simultaneous AW and AR: both accepted in the same cycle; the channels are fully independent.
- Same-cycle read and write of one index: read-first, i.e. the read returns the old data.
- One outstanding transaction per direction; no reordering.
- Reset mid-burst: both FSMs go to IDLE; partial writes already performed stay in RAM.

Optional Feature:
- Macro AXI_SLV_BP_EN (backpressure injection for verification).
- Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on rst) advances every clk.
  - In W_DATA, wready is forced 0 when lfsr[0]=1.
  - In R_DATA, a new beat is withheld (rvalid=0) when lfsr[1]=1. Once rvalid=1 it is held until the handshake.
  - wlast still aligns with the last accepted beat.
- Undefined: no LFSR; wready and rvalid behave exactly as described above.

Test Plan:
- Single beat: AW addr=0x000 len=0 id=3, wdata=A5..A5, wstrb all 1 -> wlast with first wready; bvalid, bid=3, bresp=0. Then AR addr=0 len=0 -> rdata=A5..A5, rlast=1, rid=3, rresp=0, rvalid 2 clks after AR handshake.
- 16-beat burst: write addr=0x40 len=15 data=beat number; read back with rready=1 -> 16 consecutive rvalid cycles, data 0..15, rlast on the 16th.
- Strobes: write 0xFF.. full, then wstrb=0x0000000F with data 0x11.. -> readback has low 4 bytes 0x11, the rest 0xFF.
- Wrap/backpressure: write addr=(MEM_DEPTH-2)*8 len=3, read it with rready toggling 1010 -> beats land at indices 1022, 1023, 0, 1; rdata stable while rready=0.
- Error and reset: AW with awburst=2'b10 -> bresp=2'b10. rst pulsed mid-read burst -> rvalid=0, arready=1 on the clk after reset release.
